// File: rtl/ama_riscv_retire_tracer_pkg.sv
// Shared types for the retirement tracer: the per-instruction sideband carried
// down the shadow pipe and the trace record pushed into the FIFO.
package ama_riscv_retire_tracer_pkg;

    localparam int ARCH_WIDTH = 32;
    localparam int INST_WIDTH = 32;
    localparam logic [3:0] DMEM_SIZE_NA = 4'd8;

    typedef struct packed {
        logic                  branch;
        logic                  taken;
        logic                  bp_hit;
        logic [ARCH_WIDTH-1:0] dmem_addr;
        logic [3:0]            dmem_size;
    } sideband_t;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ARCH_WIDTH-1:0] pc;
        logic                  branch;
        logic                  taken;
        logic                  bp_hit;
        logic [ARCH_WIDTH-1:0] dmem_addr;
        logic [3:0]            dmem_size;
    } retire_rec_t;

    function automatic sideband_t sb_rst();
        sideband_t s;
        s           = '0;
        s.dmem_size = DMEM_SIZE_NA;
        return s;
    endfunction

endpackage

// File: rtl/ama_riscv_trace_fifo.sv
// Registered trace FIFO with a selectable full policy. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a count register.
module ama_riscv_trace_fifo #(
    parameter type T           = logic,
    parameter int  DEPTH       = 8,
    parameter bit  DROP_OLDEST = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty,
    output logic o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    T            r_mem [DEPTH];

    logic w_pop;
    logic w_wr_en;
    logic w_rd_adv;

    assign o_empty  = (r_wr == r_rd);
    assign o_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop    = i_pop & ~o_empty;
    assign o_drop   = i_push & o_full & ~w_pop;
    // Overwrite-oldest reuses the head slot: writing at wr lands on rd when full.
    assign w_wr_en  = i_push & (~o_full | w_pop | DROP_OLDEST);
    assign w_rd_adv = w_pop | (o_drop & DROP_OLDEST);
    assign o_data   = o_empty ? T'('0) : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_wr_en)  r_wr <= r_wr + 1'b1;
            if (w_rd_adv) r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ama_riscv_retire_tracer.sv
// Retirement tracer: shadows EXE sideband down to RET, forms trace records,
// buffers them without ever stalling the core, and keeps saturating counters.
module ama_riscv_retire_tracer
    import ama_riscv_retire_tracer_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 32,
    parameter bit DROP_OLDEST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STAGES-1:0]     stage_en,
    input  logic [STAGES-1:0]     stage_flush,
    input  logic                  exe_branch,
    input  logic                  exe_taken,
    input  logic                  exe_bp_hit,
    input  logic                  exe_dmem_valid,
    input  logic [ARCH_WIDTH-1:0] exe_dmem_addr,
    input  logic [2:0]            exe_dmem_size,
    input  logic                  inst_retired,
    input  logic [INST_WIDTH-1:0] inst_ret,
    input  logic [ARCH_WIDTH-1:0] pc_ret,
    output logic                  trc_valid,
    input  logic                  trc_ready,
    output retire_rec_t           trc_rec,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_ret,
    output logic [CNT_W-1:0]      cnt_br,
    output logic [CNT_W-1:0]      cnt_taken,
    output logic [CNT_W-1:0]      cnt_bp_hit,
    output logic [CNT_W-1:0]      cnt_dmem,
    output logic [CNT_W-1:0]      cnt_drop
);

    sideband_t   w_sb_exe;
    sideband_t   w_sb_ret;
    retire_rec_t w_rec;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_drop;
    logic [5:0]  w_inc;

    always_comb begin
        w_sb_exe.branch    = exe_branch;
        w_sb_exe.taken     = exe_branch & exe_taken;
        w_sb_exe.bp_hit    = exe_branch & exe_bp_hit;
        w_sb_exe.dmem_addr = exe_dmem_valid ? exe_dmem_addr : '0;
        w_sb_exe.dmem_size = exe_dmem_valid ? {1'b0, exe_dmem_size} : DMEM_SIZE_NA;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        sideband_t w_in;
        sideband_t r_sb;
        if (k == 0) begin : g_head
            assign w_in = w_sb_exe;
        end else begin : g_body
            assign w_in = g_stage[k-1].r_sb;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              r_sb <= sb_rst();
            else if (stage_flush[k]) r_sb <= sb_rst();
            else if (stage_en[k])    r_sb <= w_in;
        end
    end

    assign w_sb_ret = g_stage[STAGES-1].r_sb;

    always_comb begin
        w_rec.inst      = inst_ret;
        w_rec.pc        = pc_ret;
        w_rec.branch    = w_sb_ret.branch;
        w_rec.taken     = w_sb_ret.taken;
        w_rec.bp_hit    = w_sb_ret.bp_hit;
        w_rec.dmem_addr = w_sb_ret.dmem_addr;
        w_rec.dmem_size = w_sb_ret.dmem_size;
    end

    ama_riscv_trace_fifo #(
        .T           (retire_rec_t),
        .DEPTH       (FIFO_DEPTH),
        .DROP_OLDEST (DROP_OLDEST)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (inst_retired),
        .i_data  (w_rec),
        .i_pop   (trc_ready),
        .o_data  (trc_rec),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_drop  (w_fifo_drop)
    );

    assign trc_valid = ~w_fifo_empty;

    a_drop_only_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        w_fifo_drop |-> (inst_retired && w_fifo_full));

    assign w_inc = {w_fifo_drop,
                    inst_retired & (w_sb_ret.dmem_size != DMEM_SIZE_NA),
                    inst_retired & w_sb_ret.bp_hit,
                    inst_retired & w_sb_ret.taken,
                    inst_retired & w_sb_ret.branch,
                    inst_retired};

    for (genvar i = 0; i < 6; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                   r_cnt <= '0;
            else if (cnt_clr)             r_cnt <= '0;
            else if (w_inc[i] && ~&r_cnt) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_ret    = g_cnt[0].r_cnt;
    assign cnt_br     = g_cnt[1].r_cnt;
    assign cnt_taken  = g_cnt[2].r_cnt;
    assign cnt_bp_hit = g_cnt[3].r_cnt;
    assign cnt_dmem   = g_cnt[4].r_cnt;
    assign cnt_drop   = g_cnt[5].r_cnt;

endmodule

// File: tb/tb_ama_riscv_retire_tracer.sv
// Bench for the retirement tracer: two instances (discard-new / overwrite-oldest)
// share stimulus and are compared every cycle against a queue-based model.
module tb_ama_riscv_retire_tracer;
    import ama_riscv_retire_tracer_pkg::*;

    localparam int STG = 3;
    localparam int DEP = 4;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [STG-1:0]        stage_en, stage_flush;
    logic                  exe_branch, exe_taken, exe_bp_hit, exe_dmem_valid;
    logic [ARCH_WIDTH-1:0] exe_dmem_addr;
    logic [2:0]            exe_dmem_size;
    logic                  inst_retired;
    logic [INST_WIDTH-1:0] inst_ret;
    logic [ARCH_WIDTH-1:0] pc_ret;
    logic                  trc_ready, cnt_clr;
    logic [1:0]            trc_valid;
    retire_rec_t [1:0]     trc_rec;
    logic [1:0][5:0][CW-1:0] cnt;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        ama_riscv_retire_tracer #(
            .STAGES(STG), .FIFO_DEPTH(DEP), .CNT_W(CW), .DROP_OLDEST(d == 1)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .stage_en(stage_en), .stage_flush(stage_flush),
            .exe_branch(exe_branch), .exe_taken(exe_taken), .exe_bp_hit(exe_bp_hit),
            .exe_dmem_valid(exe_dmem_valid), .exe_dmem_addr(exe_dmem_addr),
            .exe_dmem_size(exe_dmem_size),
            .inst_retired(inst_retired), .inst_ret(inst_ret), .pc_ret(pc_ret),
            .trc_valid(trc_valid[d]), .trc_ready(trc_ready), .trc_rec(trc_rec[d]),
            .cnt_clr(cnt_clr),
            .cnt_ret(cnt[d][0]), .cnt_br(cnt[d][1]), .cnt_taken(cnt[d][2]),
            .cnt_bp_hit(cnt[d][3]), .cnt_dmem(cnt[d][4]), .cnt_drop(cnt[d][5])
        );
    end

    // Reference model
    typedef struct { bit br; bit tk; bit hit; bit [31:0] addr; bit [3:0] size; } sbm_t;
    sbm_t        shm [STG];
    retire_rec_t mq [2][$];
    int          mc [2][6];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic sbm_t sb_na();
        sbm_t s;
        s.br = 0; s.tk = 0; s.hit = 0; s.addr = 32'd0; s.size = 4'd8;
        return s;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < STG; k++) shm[k] = sb_na();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            for (int i = 0; i < 6; i++) mc[d][i] = 0;
        end
    endfunction

    function automatic void model_step();
        sbm_t        ret;
        sbm_t        nxt;
        retire_rec_t rec;
        bit          pop, drop;
        bit [5:0]    ev;
        ret = shm[STG-1];
        rec.inst = inst_ret; rec.pc = pc_ret;
        rec.branch = ret.br; rec.taken = ret.tk; rec.bp_hit = ret.hit;
        rec.dmem_addr = ret.addr; rec.dmem_size = ret.size;
        for (int d = 0; d < 2; d++) begin
            pop  = (mq[d].size() > 0) && trc_ready;
            drop = inst_retired && (mq[d].size() == DEP) && !pop;
            ev[0] = inst_retired;
            ev[1] = inst_retired && ret.br;
            ev[2] = inst_retired && ret.tk;
            ev[3] = inst_retired && ret.hit;
            ev[4] = inst_retired && (ret.size != 4'd8);
            ev[5] = drop;
            if (pop) void'(mq[d].pop_front());
            if (inst_retired) begin
                if (!drop) mq[d].push_back(rec);
                else if (d == 1) begin
                    void'(mq[d].pop_front());
                    mq[d].push_back(rec);
                end
            end
            for (int i = 0; i < 6; i++)
                if (cnt_clr) mc[d][i] = 0;
                else if (ev[i] && mc[d][i] < MAXC) mc[d][i] = mc[d][i] + 1;
        end
        for (int k = STG - 1; k >= 0; k--) begin
            if (k == 0) begin
                nxt.br   = exe_branch;
                nxt.tk   = exe_branch & exe_taken;
                nxt.hit  = exe_branch & exe_bp_hit;
                nxt.addr = exe_dmem_valid ? exe_dmem_addr : 32'd0;
                nxt.size = exe_dmem_valid ? {1'b0, exe_dmem_size} : 4'd8;
            end else nxt = shm[k-1];
            if (stage_flush[k]) shm[k] = sb_na();
            else if (stage_en[k]) shm[k] = nxt;
        end
    endfunction

    task automatic check_all();
        retire_rec_t exp;
        for (int d = 0; d < 2; d++) begin
            exp = (mq[d].size() > 0) ? mq[d][0] : '0;
            chk($sformatf("valid%0d", d), trc_valid[d], mq[d].size() > 0);
            chk($sformatf("rec%0d", d), trc_rec[d], exp);
            for (int i = 0; i < 6; i++)
                chk($sformatf("cnt%0d_%0d", d, i), cnt[d][i], mc[d][i]);
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        stage_en = '1; stage_flush = '0;
        exe_branch = 0; exe_taken = 0; exe_bp_hit = 0;
        exe_dmem_valid = 0; exe_dmem_addr = '0; exe_dmem_size = '0;
        inst_retired = 0; inst_ret = '0; pc_ret = '0;
        trc_ready = 0; cnt_clr = 0;
    endtask

    task automatic retire(input logic [31:0] pc);
        inst_retired = 1; pc_ret = pc; inst_ret = 32'h13 ^ pc;
    endtask

    task automatic drain();
        idle(); trc_ready = 1;
        repeat (DEP + 1) tick();
        trc_ready = 0;
    endtask

    task automatic rnd_inputs();
        stage_en       = ($urandom_range(0, 4) == 0) ? STG'($urandom) : '1;
        stage_flush    = ($urandom_range(0, 9) == 0) ? STG'($urandom) : '0;
        exe_branch     = 1'($urandom);
        exe_taken      = 1'($urandom);
        exe_bp_hit     = 1'($urandom);
        exe_dmem_valid = 1'($urandom);
        exe_dmem_addr  = $urandom;
        exe_dmem_size  = 3'($urandom);
        inst_retired   = $urandom_range(0, 2) != 0;
        inst_ret       = $urandom;
        pc_ret         = $urandom;
        trc_ready      = 1'($urandom);
        cnt_clr        = $urandom_range(0, 40) == 0;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1;

        // lw at 0x100 reaches RET after three enabled cycles
        exe_dmem_valid = 1; exe_dmem_addr = 32'h100; exe_dmem_size = 3'd2;
        tick();
        idle();
        repeat (2) tick();
        retire(32'h40);
        chk("align_pre_valid", trc_valid[0], 1'b0);
        tick();
        idle();
        chk("align_valid", trc_valid[0], 1'b1);
        chk("align_addr", trc_rec[0].dmem_addr, 32'h100);
        chk("align_size", trc_rec[0].dmem_size, 4'd2);
        chk("align_cnt_dmem", cnt[0][4], 4'd1);
        drain();

        // taken branch flushed in stage 1
        exe_branch = 1; exe_taken = 1;
        tick();
        idle(); stage_flush = 3'b010;
        tick();
        idle();
        tick();
        retire(32'h80);
        tick();
        idle();
        chk("flush_branch", trc_rec[0].branch, 1'b0);
        chk("flush_taken", trc_rec[0].taken, 1'b0);
        drain();

        // whole-pipe stall for two cycles keeps sideband with the late retire
        exe_dmem_valid = 1; exe_dmem_addr = 32'h200; exe_dmem_size = 3'd6;
        tick();
        idle();
        tick();
        stage_en = '0;
        repeat (2) tick();
        stage_en = '1;
        tick();
        retire(32'hC0);
        tick();
        idle();
        chk("stall_addr", trc_rec[0].dmem_addr, 32'h200);
        chk("stall_size", trc_rec[0].dmem_size, 4'd6);
        drain();

        // overflow: six retires into a four-deep FIFO
        cnt_clr = 1; tick(); idle();
        for (int j = 0; j < 6; j++) begin
            retire(32'(j * 4));
            tick();
        end
        idle();
        chk("ovf_drop0", cnt[0][5], 4'd2);
        chk("ovf_drop1", cnt[1][5], 4'd2);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("ovf_pc0_%0d", j), trc_rec[0].pc, 32'(j * 4));
            chk($sformatf("ovf_pc1_%0d", j), trc_rec[1].pc, 32'((j + 2) * 4));
            trc_ready = 1;
            tick();
        end
        idle();
        chk("ovf_empty0", trc_valid[0], 1'b0);
        // full exchange does not drop
        for (int j = 0; j < 4; j++) begin
            retire(32'h100 + 32'(j * 4));
            tick();
        end
        retire(32'h200); trc_ready = 1;
        tick();
        idle();
        chk("xchg_drop0", cnt[0][5], 4'd2);
        chk("xchg_drop1", cnt[1][5], 4'd2);
        drain();

        // counter saturation and clear priority
        cnt_clr = 1; tick(); idle();
        for (int j = 0; j < 17; j++) begin
            retire(32'h1000 + 32'(j * 4)); trc_ready = 1;
            tick();
        end
        idle();
        chk("sat_ret", cnt[0][0], 4'd15);
        retire(32'h2000); cnt_clr = 1;
        tick();
        idle();
        chk("clr_ret", cnt[0][0], 4'd0);
        drain();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rnd_inputs();
            tick();
        end
        drain();

        // asynchronous reset with records queued
        for (int j = 0; j < 3; j++) begin
            exe_dmem_valid = 1; exe_dmem_addr = 32'h300; exe_dmem_size = 3'd1;
            retire(32'h3000 + 32'(j * 4));
            tick();
        end
        idle();
        chk("pre_rst_valid", trc_valid[0], 1'b1);
        #2 rst_n = 0;
        #1;
        chk("rst_valid0", trc_valid[0], 1'b0);
        chk("rst_valid1", trc_valid[1], 1'b0);
        chk("rst_cnt_ret", cnt[0][0], 4'd0);
        chk("rst_cnt_dmem", cnt[1][4], 4'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        check_all();
        stage_en = '0;
        retire(32'h4000);
        tick();
        idle();
        chk("rst_shadow_size0", trc_rec[0].dmem_size, 4'd8);
        chk("rst_shadow_size1", trc_rec[1].dmem_size, 4'd8);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ama_riscv_retire_tracer.md
# ama_riscv_retire_tracer

Parametrised retirement tracer for the verification environment. It carries per-instruction sideband (branch, taken, BP hit, dmem address/size) from EXE to retirement through a configurable-depth shadow pipeline. It merges that sideband with the retired inst/PC into a trace record and buffers records in a FIFO drained over a valid/ready port. It also keeps saturating event counters and a drop counter. It binds alongside the core and must never back-pressure it.

## Interface
Parameters:
- `STAGES`, 3: shadow registers between EXE and RET (1..8).
- `FIFO_DEPTH`, 8: trace FIFO entries, power of two, at least 2.
- `CNT_W`, 32: event counter width.
- `DROP_OLDEST`, 0: FIFO full-policy select. 0 discards the incoming record; 1 overwrites the oldest record.

Ports (clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous active-low reset.
- `stage_en` in STAGES: per-stage load enable. Bit k feeds shadow register k.
- `stage_flush` in STAGES: per-stage flush. Bit k loads the reset value into register k.
- `exe_branch` in 1: EXE instruction is a branch.
- `exe_taken` in 1: EXE branch resolved taken.
- `exe_bp_hit` in 1: EXE branch predicted correctly.
- `exe_dmem_valid` in 1: EXE issues a dmem request.
- `exe_dmem_addr` in ARCH_WIDTH: dmem request address.
- `exe_dmem_size` in 3: `{rtype,dtype}` encoding; lb/lh/lw/ld are 0-3, sb/sh/sw/sd are 4-7.
- `inst_retired` in 1: an instruction retires this cycle.
- `inst_ret` in INST_WIDTH: retired instruction word.
- `pc_ret` in ARCH_WIDTH: retired PC.
- `trc_valid` out 1: FIFO head record is valid.
- `trc_ready` in 1: consumer accepts the head record.
- `trc_rec` out retire_rec_t: head record.
- `cnt_clr` in 1: synchronous clear of all counters.
- `cnt_ret`, `cnt_br`, `cnt_taken`, `cnt_bp_hit`, `cnt_dmem`, `cnt_drop` out CNT_W each: event counters.

## Operation
- **EXE qualification:**
  - `taken_exe = exe_branch & exe_taken`
  - `bp_hit_exe = exe_branch & exe_bp_hit`
  - `addr_exe = exe_dmem_valid ? exe_dmem_addr : 0`
  - `size_exe = exe_dmem_valid ? {1'b0,exe_dmem_size} : DMEM_SIZE_NA`, where DMEM_SIZE_NA is 8.
- **Shadow register k:**
  - Input is the EXE-qualified fields for k=0, otherwise the output of register k-1.
  - Flush has priority: load reset value.
  - Otherwise, if `stage_en[k]`, load the input.
  - Otherwise hold.
  - Reset value is all fields 0, except size = DMEM_SIZE_NA.
- **Record formation:** the RET sideband is the output of register STAGES-1. When `inst_retired` is high, the record is `{inst_ret, pc_ret, sideband}`. When it is low, there is no push.
- **FIFO push:** occurs on `inst_retired`.
  - Pop occurs on `trc_valid & trc_ready`.
  - When full, push and pop in the same cycle is a normal exchange with no drop.
  - When full, push without pop depends on `DROP_OLDEST`:
    - 0: the incoming record is discarded.
    - 1: the head is discarded, the read pointer advances, and the new record is written.
    - In both cases `cnt_drop` increments.
  - When empty, a pop is impossible and `trc_rec` reads 0.
- **Counters:**
  - `cnt_ret` increments per retire.
  - `cnt_br`, `cnt_taken`, `cnt_bp_hit` increment per retired record with that bit set.
  - `cnt_dmem` increments per retired record with size != NA.
  - All counters saturate at all-ones.
  - `cnt_clr` wins over a same-cycle increment.

## Timing
- **Reset:** asynchronous on `rst_n` low, released synchronously to `clk`. All outputs are 0 and the FIFO is empty. A reset mid-operation discards FIFO contents and the shadow pipe.
- **Latency:**
  - EXE sideband to RET is STAGES enabled cycles.
  - Retire to `trc_valid` is 1 cycle (registered FIFO, no bypass).
- **Handshake:** `trc_rec` is stable while `trc_valid & ~trc_ready`. The exception is `DROP_OLDEST=1` on overflow, where the head changes and the drop is counted.
- **Counter timing:** counters update on the cycle after the event.

## Structure
- Package contents: `retire_rec_t` (inst, pc, branch, taken, bp_hit, dmem_addr, dmem_size[3:0]) and `DMEM_SIZE_NA`.
- Sub-module: `ama_riscv_trace_fifo`.
  - Parametrised on type, depth and drop policy.
  - Pointers are log2(DEPTH)+1 bits wide, with the extra wrap bit distinguishing full from empty.
  - Outputs full/empty and a drop pulse.
- Shadow pipe: a generate loop over STAGES in the top module.

## Test plan
- **Sideband alignment:** STAGES=3, all `stage_en`=1, EXE lw at addr 0x100, retire 3 cycles later. Required: record addr 0x100, size 2; `trc_valid` one cycle after retire; `cnt_dmem`=1.
- **Flush and stall:** taken branch at EXE, `stage_flush[1]`=1 when the branch reaches stage 1. Required: retired record has branch=0, taken=0. Separately, hold `stage_en[2]`=0 for 2 cycles; the sideband must stay aligned with the delayed retire.
- **Overflow, DROP_OLDEST=0:** DEPTH=4, `trc_ready`=0, 6 retires with PCs 0x0,0x4,…,0x14. Required: FIFO holds 0x0-0xC; `cnt_drop`=2; draining yields 0x0,0x4,0x8,0xC.
- **Overflow, DROP_OLDEST=1:** same stimulus. Required: drain yields 0x8,0xC,0x10,0x14; `cnt_drop`=2. Full push+pop in the same cycle gives no drop.
- **Counter edges:** CNT_W=4, 17 retires. Required: `cnt_ret`=15, saturated. `cnt_clr` asserted together with a retire gives `cnt_ret`=0.
- **Mid-operation reset:** assert `rst_n`=0 with 3 records queued. Required: `trc_valid` goes 0 immediately (asynchronous); all counters 0; shadow size fields = 8.
